timer_controller: RTL and testbench

//  Sequencing controller wrapped around an N-bit up-counter datapath.

---
 rtl/timer_controller.sv | 152 +++++++++++++++
 tb/tb_timer_controller.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/timer_controller.sv
// -----------------------------------------------------------------------------
// timer_controller
//   Programmable timer built around an N-bit up-counter. The counter advances
//   once every (prescale+1) clock cycles and wraps at the programmed terminal
//   count P. In one-shot mode a single period completes the run. In periodic
//   mode the run repeats until it is stopped.
//
// Ports
//   clk       system clock; all logic runs on the rising edge
//   reset     synchronous, active-high; overrides every other input
//   start     level; launches a run from IDLE
//   stop      level; aborts a run and wins over a same-cycle start
//   mode      0 = one-shot, 1 = periodic (latched at start)
//   period    terminal count P, latched at start; P = 0 never launches a run
//   prescale  divider S, latched at start; count advances every S+1 cycles
//   count     current count, 0..P-1
//   busy      high while running
//   tick      one-cycle pulse on every period completion
//   done      one-cycle pulse when a one-shot run completes
// -----------------------------------------------------------------------------
module timer_controller #(
  parameter int unsigned N       = 8,
  parameter int unsigned PRESC_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [N-1:0]       period,
  input  logic [PRESC_W-1:0] prescale,
  output logic [N-1:0]       count,
  output logic               busy,
  output logic               tick,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q,  state_d;
  logic [N-1:0]       count_q,  count_d;
  logic [PRESC_W-1:0] pre_q,    pre_d;
  logic [N-1:0]       period_q, period_d;
  logic [PRESC_W-1:0] presc_q,  presc_d;
  logic               mode_q,   mode_d;
  logic               busy_q,   busy_d;
  logic               tick_q,   tick_d;
  logic               done_q,   done_d;

  logic               en;
  logic               terminal;

  // Prescaler strobe: one count step per (S+1) cycles of RUN.
  assign en       = (pre_q == presc_q);
  assign terminal = (count_q == period_q - 1'b1);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    pre_d    = pre_q;
    period_d = period_q;
    presc_d  = presc_q;
    mode_d   = mode_q;
    tick_d   = 1'b0;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && !stop && (period != '0)) begin
          period_d = period;
          presc_d  = prescale;
          mode_d   = mode;
          count_d  = '0;
          pre_d    = '0;
          state_d  = RUN;
        end
      end

      RUN: begin
        // stop outranks a same-cycle terminal event, so no tick/done leaks out
        if (stop) begin
          count_d = '0;
          pre_d   = '0;
          state_d = IDLE;
        end else begin
          pre_d = en ? '0 : pre_q + 1'b1;
          if (en) begin
            if (terminal) begin
              count_d = '0;
              tick_d  = 1'b1;
              if (!mode_q) begin
                done_d  = 1'b1;
                state_d = DONE;
              end
            end else begin
              count_d = count_q + 1'b1;
            end
          end
        end
      end

      DONE: begin
        count_d = '0;
        pre_d   = '0;
        state_d = IDLE;
      end

      default: begin
        count_d = '0;
        pre_d   = '0;
        state_d = IDLE;
      end
    endcase

    // busy is registered alongside the state so that it reflects the new state
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      pre_q    <= '0;
      period_q <= '0;
      presc_q  <= '0;
      mode_q   <= 1'b0;
      busy_q   <= 1'b0;
      tick_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      pre_q    <= pre_d;
      period_q <= period_d;
      presc_q  <= presc_d;
      mode_q   <= mode_d;
      busy_q   <= busy_d;
      tick_q   <= tick_d;
      done_q   <= done_d;
    end
  end

  assign count = count_q;
  assign busy  = busy_q;
  assign tick  = tick_q;
  assign done  = done_q;

endmodule

// File: tb/tb_timer_controller.sv
// -----------------------------------------------------------------------------
// tb_timer_controller
//   Per-cycle vectors: each record holds the inputs driven before one clock
//   edge and the outputs expected right after that edge. Drivers queue the
//   expectation, and a monitor pops it just after the edge and compares.
// -----------------------------------------------------------------------------
module tb_timer_controller;

  localparam int unsigned N       = 8;
  localparam int unsigned PRESC_W = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic               stop;
  logic               mode;
  logic [N-1:0]       period;
  logic [PRESC_W-1:0] prescale;
  logic [N-1:0]       count;
  logic               busy;
  logic               tick;
  logic               done;

  timer_controller #(.N(N), .PRESC_W(PRESC_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .mode     (mode),
    .period   (period),
    .prescale (prescale),
    .count    (count),
    .busy     (busy),
    .tick     (tick),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string              name;
    logic               rst;
    logic               st;
    logic               sp;
    logic               md;
    logic [N-1:0]       p;
    logic [PRESC_W-1:0] s;
    logic [N-1:0]       c;
    logic               b;
    logic               t;
    logic               d;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(string nm, logic r, logic st, logic sp, logic md,
                              logic [N-1:0] p, logic [PRESC_W-1:0] s,
                              logic [N-1:0] c, logic b, logic t, logic d);
    vec_t v;
    v.name = nm; v.rst = r; v.st = st; v.sp = sp; v.md = md; v.p = p; v.s = s;
    v.c = c; v.b = b; v.t = t; v.d = d;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    @(negedge clk);
    reset    = v.rst;
    start    = v.st;
    stop     = v.sp;
    mode     = v.md;
    period   = v.p;
    prescale = v.s;
    exp_q.push_back(v);
  endtask

  // Scoreboard consumer: the vector driven before this edge is checked here.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      vec_t e;
      e = exp_q.pop_front();
      checks++;
      if (count !== e.c || busy !== e.b || tick !== e.t || done !== e.d) begin
        errors++;
        $display("FAIL %s: got count=%0d busy=%0b tick=%0b done=%0b, want count=%0d busy=%0b tick=%0b done=%0b",
                 e.name, count, busy, tick, done, e.c, e.b, e.t, e.d);
      end
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0;
    period = '0; prescale = '0;

    // Reset held with start asserted
    for (int i = 0; i < 3; i++) tbl.push_back(mk("reset_hold", 1, 1, 0, 1, 4, 0, 0, 0, 0, 0));
    tbl.push_back(mk("post_reset_idle", 0, 0, 0, 0, 4, 0, 0, 0, 0, 0));

    // Periodic P=4 S=0; from the 6th cycle on, start with P=9/S=3/mode=0 must be ignored
    tbl.push_back(mk("p4_start", 0, 1, 0, 1, 4, 0, 0, 1, 0, 0));
    tbl.push_back(mk("p4_e1", 0, 0, 0, 1, 4, 0, 1, 1, 0, 0));
    tbl.push_back(mk("p4_e2", 0, 0, 0, 1, 4, 0, 2, 1, 0, 0));
    tbl.push_back(mk("p4_e3", 0, 0, 0, 1, 4, 0, 3, 1, 0, 0));
    tbl.push_back(mk("p4_tick1", 0, 0, 0, 1, 4, 0, 0, 1, 1, 0));
    tbl.push_back(mk("p4_e5", 0, 1, 0, 0, 9, 3, 1, 1, 0, 0));
    tbl.push_back(mk("p4_e6", 0, 1, 0, 0, 9, 3, 2, 1, 0, 0));
    tbl.push_back(mk("p4_e7", 0, 1, 0, 0, 9, 3, 3, 1, 0, 0));
    tbl.push_back(mk("p4_tick2", 0, 1, 0, 0, 9, 3, 0, 1, 1, 0));
    tbl.push_back(mk("p4_e9", 0, 1, 0, 0, 9, 3, 1, 1, 0, 0));
    tbl.push_back(mk("p4_e10", 0, 1, 0, 0, 9, 3, 2, 1, 0, 0));
    tbl.push_back(mk("p4_e11", 0, 1, 0, 0, 9, 3, 3, 1, 0, 0));
    tbl.push_back(mk("p4_tick3", 0, 1, 0, 0, 9, 3, 0, 1, 1, 0));
    tbl.push_back(mk("p4_stop", 0, 0, 1, 0, 4, 0, 0, 0, 0, 0));

    // One-shot P=3 S=2; start held in the DONE cycle is ignored
    tbl.push_back(mk("os_start", 0, 1, 0, 0, 3, 2, 0, 1, 0, 0));
    tbl.push_back(mk("os_e1", 0, 0, 0, 0, 3, 2, 0, 1, 0, 0));
    tbl.push_back(mk("os_e2", 0, 0, 0, 0, 3, 2, 0, 1, 0, 0));
    tbl.push_back(mk("os_e3", 0, 0, 0, 0, 3, 2, 1, 1, 0, 0));
    tbl.push_back(mk("os_e4", 0, 0, 0, 0, 3, 2, 1, 1, 0, 0));
    tbl.push_back(mk("os_e5", 0, 0, 0, 0, 3, 2, 1, 1, 0, 0));
    tbl.push_back(mk("os_e6", 0, 0, 0, 0, 3, 2, 2, 1, 0, 0));
    tbl.push_back(mk("os_e7", 0, 0, 0, 0, 3, 2, 2, 1, 0, 0));
    tbl.push_back(mk("os_e8", 0, 0, 0, 0, 3, 2, 2, 1, 0, 0));
    tbl.push_back(mk("os_done", 0, 0, 0, 0, 3, 2, 0, 0, 1, 1));
    tbl.push_back(mk("os_done_state_start", 0, 1, 0, 0, 3, 2, 0, 0, 0, 0));
    tbl.push_back(mk("os_idle", 0, 0, 0, 0, 3, 2, 0, 0, 0, 0));

    // Periodic P=5: early stop, then stop on the terminal count
    tbl.push_back(mk("p5_start", 0, 1, 0, 1, 5, 0, 0, 1, 0, 0));
    tbl.push_back(mk("p5_e1", 0, 0, 0, 1, 5, 0, 1, 1, 0, 0));
    tbl.push_back(mk("p5_e2", 0, 0, 0, 1, 5, 0, 2, 1, 0, 0));
    tbl.push_back(mk("p5_stop_mid", 0, 0, 1, 1, 5, 0, 0, 0, 0, 0));
    tbl.push_back(mk("p5_restart", 0, 1, 0, 1, 5, 0, 0, 1, 0, 0));
    tbl.push_back(mk("p5_r1", 0, 0, 0, 1, 5, 0, 1, 1, 0, 0));
    tbl.push_back(mk("p5_r2", 0, 0, 0, 1, 5, 0, 2, 1, 0, 0));
    tbl.push_back(mk("p5_r3", 0, 0, 0, 1, 5, 0, 3, 1, 0, 0));
    tbl.push_back(mk("p5_r4", 0, 0, 0, 1, 5, 0, 4, 1, 0, 0));
    tbl.push_back(mk("p5_stop_terminal", 0, 0, 1, 1, 5, 0, 0, 0, 0, 0));

    // Zero period never launches
    tbl.push_back(mk("p0_start", 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("p0_hold", 0, 1, 0, 0, 0, 3, 0, 0, 0, 0));

    // Reset in the middle of a P=8 run, then start+stop together
    tbl.push_back(mk("p8_start", 0, 1, 0, 1, 8, 0, 0, 1, 0, 0));
    tbl.push_back(mk("p8_e1", 0, 0, 0, 1, 8, 0, 1, 1, 0, 0));
    tbl.push_back(mk("p8_e2", 0, 0, 0, 1, 8, 0, 2, 1, 0, 0));
    tbl.push_back(mk("p8_e3", 0, 0, 0, 1, 8, 0, 3, 1, 0, 0));
    tbl.push_back(mk("p8_e4", 0, 0, 0, 1, 8, 0, 4, 1, 0, 0));
    tbl.push_back(mk("p8_reset", 1, 1, 0, 1, 8, 0, 0, 0, 0, 0));
    tbl.push_back(mk("start_stop_same", 0, 1, 1, 1, 8, 0, 0, 0, 0, 0));
    tbl.push_back(mk("start_stop_idle", 0, 0, 0, 1, 8, 0, 0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Maximum prescale S=15, one-shot P=2: step after 16 cycles, done after 32
    apply(mk("s15_start", 0, 1, 0, 0, 2, 15, 0, 1, 0, 0));
    for (int k = 1; k <= 32; k++) begin
      if (k == 32)
        apply(mk("s15_done", 0, 0, 0, 0, 2, 15, 0, 0, 1, 1));
      else
        apply(mk("s15_run", 0, 0, 0, 0, 2, 15, (k >= 16) ? 8'd1 : 8'd0, 1, 0, 0));
    end
    apply(mk("s15_idle", 0, 0, 0, 0, 2, 15, 0, 0, 0, 0));

    // Maximum period P=255, S=0, periodic: count tops out at 254, then ticks
    apply(mk("p255_start", 0, 1, 0, 1, 255, 0, 0, 1, 0, 0));
    for (int k = 1; k <= 256; k++) begin
      logic [N-1:0] ec;
      ec = N'(k % 255);
      apply(mk((k == 255) ? "p255_tick" : "p255_run", 0, 0, 0, 1, 255, 0, ec, 1,
               (k == 255) ? 1'b1 : 1'b0, 0));
    end
    apply(mk("p255_stop", 0, 0, 1, 1, 255, 0, 0, 0, 0, 0));

    // Drain the scoreboard within a bounded number of cycles
    for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
